// File: rtl/microwave_power_controller_pkg.sv
// Shared types and helpers for the microwave power controller.
package microwave_power_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Borrow wrap values: seconds-tens wraps to 5, every other digit to 9.
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic key_is_onehot(input logic [9:0] k);
    return (k != '0) && ((k & (k - 10'd1)) == '0);
  endfunction

  function automatic logic [3:0] key_to_bcd(input logic [9:0] k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) if (k[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/microwave_bcd_countdown.sv
// MM:SS BCD time register: keypad shift-in, clear, and borrow-chain decrement.
module microwave_bcd_countdown
  import microwave_power_controller_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    i_clock,
  input  logic                    i_resetn,
  input  logic                    i_load,
  input  logic [3:0]              i_digit,
  input  logic                    i_clr,
  input  logic                    i_dec,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_zero,
  output logic                    o_dec_zero
);

  logic [NUM_DIGITS-1:0][3:0] r_d;
  logic [NUM_DIGITS-1:0][3:0] w_dec_val;
  logic [NUM_DIGITS-1:0]      w_brw;   // borrow into digit g

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam logic [3:0] WRAP = (g == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    if (g == 0) begin : g_first
      assign w_brw[g] = 1'b1;
    end else begin : g_rest
      assign w_brw[g] = w_brw[g-1] && (r_d[g-1] == 4'd0);
    end
    assign w_dec_val[g] = !w_brw[g]           ? r_d[g] :
                          (r_d[g] == 4'd0)    ? WRAP   : r_d[g] - 4'd1;
  end

  // Digit register; load+clear together means "start fresh with this digit".
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn)              r_d <= '0;
    else if (i_load && i_clr)   r_d <= {{(NUM_DIGITS-1){4'd0}}, i_digit};
    else if (i_clr)             r_d <= '0;
    else if (i_load)            r_d <= {r_d[NUM_DIGITS-2:0], i_digit};
    else if (i_dec)             r_d <= w_dec_val;
  end

  assign o_digits   = r_d;
  assign o_zero     = (r_d == '0);
  assign o_dec_zero = (w_dec_val == '0);

endmodule

// File: rtl/microwave_power_controller.sv
// Microwave controller top: FSM, second prescaler, power-slot PWM, edge detect.
module microwave_power_controller
  import microwave_power_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLKS_PER_SEC = 100,
  parameter int POWER_LEVELS = 10,
  parameter int DONE_CYCLES  = 300
) (
  input  logic                                i_clock,
  input  logic                                i_resetn,
  input  logic [9:0]                          i_keypad,
  input  logic                                i_startn,
  input  logic                                i_stopn,
  input  logic                                i_clearn,
  input  logic                                i_door_closed,
  input  logic                                i_power_key,
  output logic [4*NUM_DIGITS-1:0]             o_digits_bcd,
  output logic [$clog2(POWER_LEVELS+1)-1:0]   o_power_level,
  output logic                                o_mag_on,
  output logic                                o_done,
  output logic [2:0]                          o_state
);

  // Prescaler is split into (slot, sub) so the PWM slot needs no divider.
  localparam int SUB    = CLKS_PER_SEC / POWER_LEVELS;
  localparam int SUB_W  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int SLOT_W = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1;
  localparam int PL_W   = $clog2(POWER_LEVELS + 1);
  localparam int DC_W   = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(POWER_LEVELS - 1);
  localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(DONE_CYCLES - 1);
  localparam logic [PL_W-1:0]   PL_MAX    = PL_W'(POWER_LEVELS);

  state_e            r_state, w_nxt_state;
  logic [PL_W-1:0]   r_level, w_nxt_level;
  logic [SUB_W-1:0]  r_sub, w_nxt_sub;
  logic [SLOT_W-1:0] r_slot, w_nxt_slot;
  logic [DC_W-1:0]   r_dcnt, w_nxt_dcnt;
  logic              r_en;
  logic [9:0]        r_key_prev;
  logic              r_startn_prev, r_pwr_prev;

  logic w_key_ev, w_start_ev, w_pwr_ev, w_start_ok, w_tick;
  logic w_ld, w_clr, w_dec, w_zero, w_dec_zero;
  logic [PL_W-1:0] w_level_dn;

  assign w_key_ev   = (r_key_prev == '0) && key_is_onehot(i_keypad);
  assign w_start_ev = r_startn_prev && !i_startn;
  assign w_pwr_ev   = i_power_key && !r_pwr_prev;
  assign w_start_ok = w_start_ev && i_door_closed && !w_zero;
  assign w_tick     = (r_slot == SLOT_LAST) && (r_sub == SUB_LAST);
  assign w_level_dn = (r_level == PL_W'(1)) ? PL_MAX : r_level - PL_W'(1);

  microwave_bcd_countdown #(.NUM_DIGITS(NUM_DIGITS)) u_cnt (
    .i_clock    (i_clock),
    .i_resetn   (i_resetn),
    .i_load     (w_ld),
    .i_digit    (key_to_bcd(i_keypad)),
    .i_clr      (w_clr),
    .i_dec      (w_dec),
    .o_digits   (o_digits_bcd),
    .o_zero     (w_zero),
    .o_dec_zero (w_dec_zero)
  );

  // Next-state, counter and digit-control decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_level = r_level;
    w_nxt_sub   = r_sub;
    w_nxt_slot  = r_slot;
    w_nxt_dcnt  = r_dcnt;
    w_ld        = 1'b0;
    w_clr       = 1'b0;
    w_dec       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_key_ev) begin
          w_ld        = 1'b1;
          w_nxt_state = ST_SET;
        end
        if (w_pwr_ev) w_nxt_level = w_level_dn;
      end
      ST_SET, ST_PAUSE: begin
        if (!i_clearn) begin
          w_clr       = 1'b1;
          w_nxt_level = PL_MAX;
          w_nxt_state = ST_IDLE;
        end else begin
          if (w_pwr_ev) w_nxt_level = w_level_dn;
          if (w_start_ok) begin
            w_nxt_state = ST_COOK;
            // Fresh cook restarts the second; resume keeps the partial one.
            if (r_state == ST_SET) begin
              w_nxt_sub  = '0;
              w_nxt_slot = '0;
            end
          end else if (w_key_ev && r_state == ST_SET) begin
            w_ld = 1'b1;
          end
        end
      end
      ST_COOK: begin
        if (!i_stopn || !i_door_closed) begin
          w_nxt_state = ST_PAUSE;
        end else if (w_tick) begin
          w_nxt_sub  = '0;
          w_nxt_slot = '0;
          w_dec      = 1'b1;
          if (w_dec_zero) begin
            w_nxt_state = ST_DONE;
            w_nxt_dcnt  = '0;
          end
        end else if (r_sub == SUB_LAST) begin
          w_nxt_sub  = '0;
          w_nxt_slot = r_slot + SLOT_W'(1);
        end else begin
          w_nxt_sub  = r_sub + SUB_W'(1);
        end
      end
      ST_DONE: begin
        if (!i_clearn) begin
          w_clr       = 1'b1;
          w_nxt_level = PL_MAX;
          w_nxt_state = ST_IDLE;
        end else if (w_key_ev) begin
          w_clr       = 1'b1;
          w_ld        = 1'b1;
          w_nxt_state = ST_SET;
        end else if (r_dcnt == DC_LAST) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_dcnt  = r_dcnt + DC_W'(1);
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State, counters, PWM enable and input edge history.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state       <= ST_IDLE;
      r_level       <= PL_MAX;
      r_sub         <= '0;
      r_slot        <= '0;
      r_dcnt        <= '0;
      r_en          <= 1'b0;
      r_key_prev    <= '0;
      r_startn_prev <= 1'b1;
      r_pwr_prev    <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_level       <= w_nxt_level;
      r_sub         <= w_nxt_sub;
      r_slot        <= w_nxt_slot;
      r_dcnt        <= w_nxt_dcnt;
      r_en          <= (w_nxt_state == ST_COOK) && (PL_W'(w_nxt_slot) < w_nxt_level);
      r_key_prev    <= i_keypad;
      r_startn_prev <= i_startn;
      r_pwr_prev    <= i_power_key;
    end
  end

  // Door gating is combinational so opening the door cuts power immediately.
  assign o_mag_on      = r_en && i_door_closed;
  assign o_done        = (r_state == ST_DONE);
  assign o_state       = r_state;
  assign o_power_level = r_level;

endmodule

// File: tb/tb_microwave_power_controller.sv
// Self-checking bench: directed scenarios plus random stimulus against a time/level model.
module tb_microwave_power_controller;

  localparam int ND = 4;
  localparam int C  = 10;
  localparam int P  = 10;
  localparam int D  = 20;

  logic            clk, resetn, startn, stopn, clearn, door, pwr;
  logic [9:0]      keypad;
  logic [4*ND-1:0] digits;
  logic [3:0]      plvl;
  logic            mag, done;
  logic [2:0]      st;

  int total = 0;
  int bad   = 0;

  // model: time held as minutes/seconds integers
  int m_st, m_min, m_sec, m_lvl, m_presc, m_dcnt;
  logic [9:0] m_pkey;
  bit m_pstart, m_ppwr;

  microwave_power_controller #(
    .NUM_DIGITS(ND), .CLKS_PER_SEC(C), .POWER_LEVELS(P), .DONE_CYCLES(D)
  ) dut (
    .i_clock(clk), .i_resetn(resetn), .i_keypad(keypad), .i_startn(startn),
    .i_stopn(stopn), .i_clearn(clearn), .i_door_closed(door), .i_power_key(pwr),
    .o_digits_bcd(digits), .o_power_level(plvl), .o_mag_on(mag), .o_done(done),
    .o_state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] bcd_of(input int mn, input int sc);
    logic [4*ND-1:0] r;
    int m;
    r = '0;
    r[3:0] = 4'(sc % 10);
    r[7:4] = 4'(sc / 10);
    m = mn;
    for (int i = 2; i < ND; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_min = 0; m_sec = 0; m_lvl = P; m_presc = 0; m_dcnt = 0;
    m_pkey = '0; m_pstart = 1'b1; m_ppwr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    bit em;
    em = (m_st == 2) && ((m_presc / (C / P)) < m_lvl) && door;
    cmp({tag, ".digits"}, 32'(digits), 32'(bcd_of(m_min, m_sec)));
    cmp({tag, ".level"},  32'(plvl),   32'(m_lvl));
    cmp({tag, ".state"},  32'(st),     32'(m_st));
    cmp({tag, ".done"},   32'(done),   32'(m_st == 4));
    cmp({tag, ".mag"},    32'(mag),    32'(em));
  endtask

  task automatic model_clear();
    m_min = 0; m_sec = 0; m_lvl = P; m_st = 0;
  endtask

  task automatic model_step();
    bit kev, sev, pev, nz;
    int d, t;
    kev = (m_pkey == '0) && ($countones(keypad) == 1);
    sev = m_pstart && !startn;
    pev = pwr && !m_ppwr;
    d = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
    nz = (m_min != 0) || (m_sec != 0);
    case (m_st)
      0: begin
        if (kev) begin
          t = ((m_min * 100 + m_sec) * 10 + d) % (10 ** ND);
          m_min = t / 100; m_sec = t % 100; m_st = 1;
        end
        if (pev) m_lvl = (m_lvl == 1) ? P : m_lvl - 1;
      end
      1, 3: begin
        if (!clearn) model_clear();
        else begin
          if (pev) m_lvl = (m_lvl == 1) ? P : m_lvl - 1;
          if (sev && door && nz) begin
            if (m_st == 1) m_presc = 0;
            m_st = 2;
          end else if (kev && m_st == 1) begin
            t = ((m_min * 100 + m_sec) * 10 + d) % (10 ** ND);
            m_min = t / 100; m_sec = t % 100;
          end
        end
      end
      2: begin
        if (!stopn || !door) m_st = 3;
        else if (m_presc == C - 1) begin
          m_presc = 0;
          if (m_sec > 0) m_sec--;
          else begin m_sec = 59; m_min--; end
          if (m_min == 0 && m_sec == 0) begin m_st = 4; m_dcnt = 0; end
        end else m_presc++;
      end
      4: begin
        if (!clearn) model_clear();
        else if (kev) begin m_min = 0; m_sec = d; m_st = 1; end
        else if (m_dcnt == D - 1) m_st = 0;
        else m_dcnt++;
      end
      default: ;
    endcase
    m_pkey = keypad; m_pstart = startn; m_ppwr = pwr;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_key(input int d);
    keypad = 10'b1 << d; cyc();
    keypad = '0;         cyc();
  endtask

  task automatic pulse_start();
    startn = 1'b0; cyc(); startn = 1'b1; cyc();
  endtask

  task automatic pulse_stop();
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
  endtask

  task automatic pulse_clear();
    clearn = 1'b0; cyc(); clearn = 1'b1; cyc();
  endtask

  task automatic press_power();
    pwr = 1'b1; cyc(); pwr = 1'b0; cyc();
  endtask

  initial begin
    int cnt, act, n;
    resetn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door = 1'b1; pwr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    cmp("reset.level_const", 32'(plvl), 32'd10);
    @(negedge clk); resetn = 1'b1;
    run(2);

    // entry and multi-hot rejection
    press_key(2); press_key(4); press_key(0); press_key(0);
    cmp("entry", 32'(digits), 32'h2400);
    cmp("entry.state", 32'(st), 32'd1);
    keypad = 10'b0000100010; cyc(); keypad = '0; cyc();
    cmp("multihot", 32'(digits), 32'h2400);
    pulse_clear();
    cmp("clear.idle", 32'(st), 32'd0);

    // full power 0:03 countdown to DONE
    press_key(3);
    pulse_start();
    cmp("cook.state", 32'(st), 32'd2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (mag) cnt++; end
    cmp("fullpower.mag", 32'(cnt), 32'd8);
    cmp("tick.before", 32'(digits), 32'h0003);
    run(1);
    cmp("tick.first", 32'(digits), 32'h0002);
    run(20);
    cmp("done.digits", 32'(digits), 32'h0000);
    cmp("done.flag", 32'(done), 32'd1);
    run(D - 1);
    cmp("done.hold", 32'(done), 32'd1);
    run(1);
    cmp("done.end", 32'(st), 32'd0);

    // borrow cases
    press_key(1); press_key(0); press_key(0);
    pulse_start(); run(9);
    cmp("borrow.100", 32'(digits), 32'h0059);
    pulse_stop(); pulse_clear();
    press_key(9); press_key(9);
    pulse_start(); run(9);
    cmp("borrow.99", 32'(digits), 32'h0098);
    pulse_stop(); pulse_clear();

    // power 3 of 10
    for (int i = 0; i < 7; i++) press_power();
    cmp("power.level", 32'(plvl), 32'd3);
    press_key(5); pulse_start();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (mag) cnt++; end
    cmp("power.duty", 32'(cnt), 32'd3);
    pulse_stop(); pulse_clear();
    cmp("power.cleared", 32'(plvl), 32'd10);

    // pause / resume from held prescaler
    press_key(2); pulse_start(); run(3);
    stopn = 1'b0; cyc();
    cmp("pause.state", 32'(st), 32'd3);
    cmp("pause.mag", 32'(mag), 32'd0);
    stopn = 1'b1; run(5);
    cmp("pause.hold", 32'(digits), 32'h0002);
    pulse_start(); run(4);
    cmp("resume.before", 32'(digits), 32'h0002);
    run(1);
    cmp("resume.tick", 32'(digits), 32'h0001);
    door = 1'b0; #1;
    check_all("door");
    cmp("door.mag", 32'(mag), 32'd0);
    cyc();
    cmp("door.pause", 32'(st), 32'd3);
    door = 1'b1; cyc();

    // clear ignored in COOK; stop+clear
    pulse_start();
    clearn = 1'b0; cyc();
    cmp("clear.cook", 32'(st), 32'd2);
    stopn = 1'b0; cyc();
    cmp("stopclear.pause", 32'(st), 32'd3);
    cyc();
    cmp("stopclear.idle", 32'(st), 32'd0);
    cmp("stopclear.digits", 32'(digits), 32'h0000);
    stopn = 1'b1; clearn = 1'b1; cyc();

    // reset mid-cook
    press_key(4); press_power(); press_power(); pulse_start(); run(3);
    resetn = 1'b0; #2;
    model_reset();
    check_all("rst_mid");
    cmp("rst_mid.mag", 32'(mag), 32'd0);
    @(negedge clk); resetn = 1'b1;
    run(2);

    // random stimulus against the model
    for (int k = 0; k < 300; k++) begin
      act = $urandom_range(0, 11);
      case (act)
        0, 1, 2: begin
          keypad = 10'b1 << $urandom_range(0, 9);
          run($urandom_range(1, 2));
          keypad = '0; run($urandom_range(1, 2));
        end
        3: begin
          keypad = 10'($urandom); run(1); keypad = '0; run(1);
        end
        4: press_power();
        5, 6: pulse_start();
        7: pulse_stop();
        8: if ($urandom_range(0, 2) == 0) pulse_clear();
        9: begin
          door = 1'b0; run($urandom_range(1, 4)); door = 1'b1; run(1);
        end
        default: begin
          n = $urandom_range(1, 25); run(n);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
